// File: rtl/delay_line_probe_if.sv
// rtl/delay_line_probe_if.sv - launch/echo/result signal bundle for the delay line probe
`timescale 1ns/1ps
interface delay_line_probe_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                   start;
  logic                   echo_in;
  logic                   launch_out;
  logic                   busy;
  logic                   done;
  logic                   timeout;
  logic [COUNT_WIDTH-1:0] delay_count;

  // Requester side: issues start, drives the delay line return, consumes results
  modport master (
    output start, echo_in,
    input  launch_out, busy, done, timeout, delay_count
  );

  // Probe side
  modport slave (
    input  start, echo_in,
    output launch_out, busy, done, timeout, delay_count
  );
endinterface

// File: rtl/delay_line_probe.sv
// rtl/delay_line_probe.sv - launches a pulse into a delay line and times the returning edge
`timescale 1ns/1ps
module delay_line_probe #(
  parameter int HIGH_CYCLES    = 10,
  parameter int LOW_CYCLES     = 100,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                clk_in,
  input  logic                rst,
  delay_line_probe_if.slave   dl
);

  localparam int PHASE_TOP = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int PW        = $clog2(PHASE_TOP + 1);
  localparam logic [COUNT_WIDTH-1:0] TMO      = COUNT_WIDTH'(TIMEOUT_CYCLES);
  localparam logic [PW-1:0]          HIGH_END = PW'(HIGH_CYCLES - 1);
  localparam logic [PW-1:0]          LOW_END  = PW'(LOW_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, LAUNCH, LISTEN, GAP} state_t;

  state_t                 state;
  logic [PW-1:0]          phase;
  logic [COUNT_WIDTH-1:0] cnt;
  logic                   meas;
  logic                   launch_r;
  logic                   busy_r;
  logic                   done_r;
  logic                   timeout_r;
  logic [COUNT_WIDTH-1:0] delay_r;
  logic                   s1, s2, s3;
  logic                   edge_det;

  assign edge_det       = s2 & ~s3;
  assign dl.launch_out  = launch_r;
  assign dl.busy        = busy_r;
  assign dl.done        = done_r;
  assign dl.timeout     = timeout_r;
  assign dl.delay_count = delay_r;

  // Bring the asynchronous echo into clk_in domain and keep one cycle of history for edge detect
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= dl.echo_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Pulse sequencing (launch, listen, quiet gap) alongside the delay measurement it brackets
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      phase     <= '0;
      cnt       <= '0;
      meas      <= 1'b0;
      launch_r  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
      delay_r   <= '0;
    end else begin
      done_r <= 1'b0;

      // The edge is checked before the timeout so a coincident edge still yields a real result
      if (meas) begin
        if (edge_det) begin
          delay_r   <= cnt;
          timeout_r <= 1'b0;
          done_r    <= 1'b1;
          meas      <= 1'b0;
        end else if (cnt == TMO) begin
          delay_r   <= TMO;
          timeout_r <= 1'b1;
          done_r    <= 1'b1;
          meas      <= 1'b0;
        end
        if (cnt != TMO) begin
          cnt <= cnt + 1'b1;
        end
      end

      case (state)
        IDLE: begin
          if (dl.start) begin
            state     <= LAUNCH;
            launch_r  <= 1'b1;
            busy_r    <= 1'b1;
            phase     <= '0;
            cnt       <= '0;
            meas      <= 1'b1;
            timeout_r <= 1'b0;
          end
        end
        LAUNCH: begin
          if (phase == HIGH_END) begin
            launch_r <= 1'b0;
            phase    <= '0;
            state    <= meas ? LISTEN : GAP;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        LISTEN: begin
          if (!meas) begin
            phase <= '0;
            state <= GAP;
          end
        end
        GAP: begin
          if (phase == LOW_END) begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_delay_line_probe.sv
// tb/tb_delay_line_probe.sv - randomized self-checking bench for delay_line_probe
`timescale 1ns/1ps
module tb_delay_line_probe;

  localparam int H  = 10;
  localparam int L  = 100;
  localparam int T  = 1000;
  localparam int CW = 16;
  localparam int NE = 1200;

  logic clk_in = 1'b0;
  logic rst    = 1'b1;
  logic echo_mode;
  logic echo_drv;
  bit   pat [NE];

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  delay_line_probe_if #(.COUNT_WIDTH(CW)) dl ();

  assign dl.echo_in = echo_mode ? echo_drv : dl.launch_out;

  delay_line_probe #(
    .HIGH_CYCLES(H),
    .LOW_CYCLES(L),
    .TIMEOUT_CYCLES(T),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk_in(clk_in),
    .rst(rst),
    .dl(dl)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Echo value in cycle j after launch is pat[j]; the probe sees it two edges later,
  // so a rising edge at index j is reported as j+2 unless the count has already hit T.
  function automatic void ref_result(input bit prior, output int d, output bit to);
    bit prev;
    prev = prior;
    d    = T;
    to   = 1'b1;
    for (int j = 0; j < NE; j++) begin
      if (pat[j] && !prev && (j + 2 <= T)) begin
        d  = j + 2;
        to = 1'b0;
        return;
      end
      prev = pat[j];
    end
  endfunction

  task automatic wait_idle();
    int n;
    n = 0;
    while (dl.busy === 1'b1 && n < 3000) begin
      @(posedge clk_in);
      #1;
      n++;
    end
    check("idle_wait", dl.busy, 0);
  endtask

  task automatic run_meas(input string tag, input bit prior);
    int d, gs, end_j, launch_n, busy_len, done_n, done_at;
    bit to;
    logic launch0, to_seen;
    logic [CW-1:0] dc_seen;
    ref_result(prior, d, to);
    // Quiet gap starts once both the pulse and the measurement are over
    gs    = (H > d + 2) ? H : d + 2;
    end_j = gs + L;
    echo_mode = 1'b1;
    echo_drv  = prior;
    wait_idle();
    repeat (4) @(posedge clk_in);
    #1 dl.start = 1'b1;
    @(posedge clk_in);
    #1 dl.start = 1'b0;
    launch_n = 0; busy_len = -1; done_n = 0; done_at = -1;
    dc_seen = '0; to_seen = 1'b0; launch0 = 1'b0;
    for (int j = 0; j < end_j + 4; j++) begin
      echo_drv = pat[j];
      if (j == 0) launch0 = dl.launch_out;
      if (dl.launch_out === 1'b1) launch_n++;
      if (dl.busy !== 1'b1 && busy_len < 0) busy_len = j;
      if (dl.done === 1'b1) begin
        done_n++;
        if (done_at < 0) begin
          done_at = j;
          dc_seen = dl.delay_count;
          to_seen = dl.timeout;
        end
      end
      @(posedge clk_in);
      #1;
    end
    check($sformatf("%s_launch_first", tag), launch0, 1);
    check($sformatf("%s_launch_width", tag), launch_n, H);
    check($sformatf("%s_busy_len", tag), busy_len, end_j);
    check($sformatf("%s_done_count", tag), done_n, 1);
    check($sformatf("%s_done_at", tag), done_at, d + 1);
    check($sformatf("%s_delay", tag), dc_seen, d);
    check($sformatf("%s_timeout", tag), to_seen, to);
    check($sformatf("%s_delay_held", tag), dl.delay_count, d);
    check($sformatf("%s_timeout_held", tag), dl.timeout, to);
  endtask

  task automatic fill_delay(input int dly);
    for (int j = 0; j < NE; j++) pat[j] = (j >= dly) && (j < dly + H);
  endtask

  task automatic fill_const(input bit v);
    for (int j = 0; j < NE; j++) pat[j] = v;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed %0d expected %0d", 1, 0);
    $fatal(1, "watchdog");
  end

  initial begin
    int rises [$];
    int ndone;
    logic prev;
    dl.start  = 1'b0;
    echo_mode = 1'b1;
    echo_drv  = 1'b0;

    #12;
    check("rst_launch", dl.launch_out, 0);
    check("rst_busy", dl.busy, 0);
    check("rst_done", dl.done, 0);
    check("rst_timeout", dl.timeout, 0);
    check("rst_delay", dl.delay_count, 0);
    @(posedge clk_in);
    #1 rst = 1'b0;

    fill_delay(0);
    run_meas("loopback", 1'b0);
    fill_delay(20);
    run_meas("delay20", 1'b0);
    fill_const(1'b0);
    run_meas("echo_low", 1'b0);
    fill_const(1'b1);
    run_meas("echo_high", 1'b1);

    fill_delay(T - 2);
    run_meas("edge_at_limit", 1'b0);

    fill_const(1'b0);
    pat[2] = 1'b1; pat[4] = 1'b1; pat[5] = 1'b1; pat[7] = 1'b1; pat[9] = 1'b1;
    run_meas("glitch_fixed", 1'b0);

    for (int k = 0; k < 3; k++) begin
      fill_delay($urandom_range(0, 40));
      run_meas($sformatf("rnd_delay%0d", k), 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      fill_const(1'b0);
      for (int j = 0; j < 15; j++) pat[j] = 1'($urandom_range(0, 1));
      run_meas($sformatf("rnd_glitch%0d", k), 1'b0);
    end
    fill_delay($urandom_range(50, 600));
    run_meas("rnd_late", 1'b0);

    // Start held continuously: each launch is followed by H high, L gap, one idle cycle
    echo_mode = 1'b0;
    wait_idle();
    dl.start = 1'b1;
    ndone = 0;
    prev  = 1'b0;
    for (int c = 0; c < 3 * (H + L + 1) - 5; c++) begin
      @(posedge clk_in);
      #1;
      if (dl.launch_out === 1'b1 && prev !== 1'b1) rises.push_back(c);
      prev = dl.launch_out;
      if (dl.done === 1'b1) begin
        ndone++;
        check("cont_delay", dl.delay_count, 2);
        check("cont_timeout", dl.timeout, 0);
      end
    end
    dl.start = 1'b0;
    check("cont_launches", rises.size(), 3);
    check("cont_done_count", ndone, 3);
    if (rises.size() == 3) begin
      check("cont_period0", rises[1] - rises[0], H + L + 1);
      check("cont_period1", rises[2] - rises[1], H + L + 1);
    end

    // Reset in the fifth launch cycle aborts the measurement without a result
    wait_idle();
    @(posedge clk_in);
    #1 dl.start = 1'b1;
    @(posedge clk_in);
    #1 dl.start = 1'b0;
    repeat (4) @(posedge clk_in);
    #3 rst = 1'b1;
    #1;
    check("abort_launch", dl.launch_out, 0);
    check("abort_busy", dl.busy, 0);
    check("abort_done", dl.done, 0);
    check("abort_delay", dl.delay_count, 0);
    @(posedge clk_in);
    #1 rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      if (dl.done === 1'b1) ndone++;
      @(posedge clk_in);
      #1;
    end
    check("abort_no_done", ndone, 0);
    check("abort_idle", dl.busy, 0);

    fill_delay(0);
    run_meas("after_abort", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
